// File: rtl/fnd_scan_rx.sv
// fnd_scan_rx: receiver for the multiplexed 6-digit FND scan bus.
// The scanned seg/dp/enb lines are synchronised and glitch-filtered.
// One digit is demultiplexed per enable phase and its 7-seg pattern is
// decoded back to BCD. A complete frame is published with a one-cycle valid pulse.
// Optional feature macro: FND_RX_ERRCNT_EN adds the o_err_cnt protocol error counter.
module fnd_scan_rx #(
    parameter int NUM_DIG     = 6,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_dec_err,
    output logic        o_frame_valid,
    output logic        o_frame_err
`ifdef FND_RX_ERRCNT_EN
    ,
    output logic [7:0]  o_err_cnt
`endif
);

    localparam int             CW          = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]  CNT_EVENT   = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0]  CNT_MAX     = CW'(STABLE_CYC);
    localparam logic [31:0]    TIMEOUT_VAL = 32'(TIMEOUT_CYC);
    localparam logic [2:0]     NUM3        = 3'(NUM_DIG);
    // Synchronizer reset value looks like an idle bus (all enables off).
    localparam logic [13:0]    SYNC_RST    = {7'h00, 1'b0, 6'h3F};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [13:0]  sync1;
    logic [13:0]  sync2;
    logic [13:0]  held;
    logic [CW-1:0] cnt;
    logic         ev_fire;
    logic [6:0]   ev_seg;
    logic         ev_dp;
    logic [5:0]   ev_enb;
    logic [2:0]   zero_cnt;
    logic [2:0]   zero_idx;
    logic         digit_ev;
    logic         multi_ev;
    logic [4:0]   dec;
    logic [2:0]   exp_slot;
    logic [2:0]   next_exp;
    logic [2:0]   exp_inc;
    logic [31:0]  timer;
    logic         store;
    logic         restart;
    logic         err;
    logic [23:0]  shadow_dig;
    logic [5:0]   shadow_dp;
    logic [5:0]   shadow_err;
    logic [5:0]   slot_mask;
    logic [23:0]  nxt_dig;
    logic [5:0]   nxt_dp;
    logic [5:0]   nxt_err;
    logic [5:0]   nxt_mask;
    logic [23:0]  pub_dig;
    logic [5:0]   pub_dp;
    logic [5:0]   pub_err;

    // Inverse 7-seg decode: {illegal flag, BCD}; an all-dark digit reads as E.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'h7E:   return 5'h00;
            7'h30:   return 5'h01;
            7'h6D:   return 5'h02;
            7'h79:   return 5'h03;
            7'h33:   return 5'h04;
            7'h5B:   return 5'h05;
            7'h5F:   return 5'h06;
            7'h70:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h73:   return 5'h09;
            7'h00:   return 5'h0E;
            default: return 5'h1F;
        endcase
    endfunction

    // Two-flop synchronizer on the raw bus, plus a copy used for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
            held  <= SYNC_RST;
        end else begin
            sync1 <= {i_seg, i_seg_dp, i_seg_enb};
            sync2 <= sync1;
            held  <= sync2;
        end
    end

    // Stability counter: restarts on any change, saturates so each stable period fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sync2 != held) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ev_fire = (cnt == CNT_EVENT);
    assign ev_seg  = held[13:7];
    assign ev_dp   = held[6];
    assign ev_enb  = held[5:0];
    assign dec     = decode_seg(ev_seg);
    assign exp_inc = exp_slot + 3'd1;

    // Count active (low) enables and remember which one was active.
    always_comb begin
        zero_cnt = 3'd0;
        zero_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!ev_enb[i]) begin
                zero_cnt = zero_cnt + 3'd1;
                zero_idx = 3'(i);
            end
        end
    end

    assign digit_ev = ev_fire && (zero_cnt == 3'd1);
    assign multi_ev = ev_fire && (zero_cnt > 3'd1);

    // Frame FSM state and expected-slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            exp_slot <= 3'd0;
        end else begin
            state    <= next_state;
            exp_slot <= next_exp;
        end
    end

    // Next-state logic: decides whether the current event stores, restarts or aborts the frame.
    always_comb begin
        next_state = state;
        next_exp   = exp_slot;
        store      = 1'b0;
        restart    = 1'b0;
        err        = 1'b0;
        case (state)
            HUNT: begin
                if (digit_ev && zero_idx == 3'd0) begin
                    store      = 1'b1;
                    restart    = 1'b1;
                    next_exp   = 3'd1;
                    next_state = (NUM_DIG == 1) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (digit_ev && zero_idx == exp_slot) begin
                    store    = 1'b1;
                    next_exp = exp_inc;
                    if (exp_inc == NUM3) begin
                        next_state = DONE;
                    end
                end else if (digit_ev && zero_idx == 3'd0) begin
                    store    = 1'b1;
                    restart  = 1'b1;
                    err      = 1'b1;
                    next_exp = 3'd1;
                end else if ((digit_ev && zero_idx < NUM3) || multi_ev ||
                             timer == TIMEOUT_VAL) begin
                    err        = 1'b1;
                    next_state = HUNT;
                end
            end
            DONE: begin
                next_state = HUNT;
            end
            default: begin
                next_state = HUNT;
            end
        endcase
    end

    // Inter-digit timer: only runs while collecting, cleared whenever a digit is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state != COLLECT || store) begin
            timer <= '0;
        end else if (timer != 32'hFFFF_FFFF) begin
            timer <= timer + 32'd1;
        end
    end

    // Next shadow contents with the current digit merged in, so DONE can publish without delay.
    always_comb begin
        nxt_dig  = shadow_dig;
        nxt_dp   = shadow_dp;
        nxt_err  = shadow_err;
        nxt_mask = slot_mask;
        if (restart) begin
            nxt_mask = '0;
        end
        if (store) begin
            for (int i = 0; i < 6; i++) begin
                if (zero_idx == 3'(i)) begin
                    nxt_dig[4*i +: 4] = dec[3:0];
                    nxt_dp[i]         = ev_dp;
                    nxt_err[i]        = dec[4];
                    nxt_mask[i]       = 1'b1;
                end
            end
        end
    end

    // Published view: slots not filled in this frame, or beyond NUM_DIG, read as zero.
    always_comb begin
        pub_dig = '0;
        pub_dp  = '0;
        pub_err = '0;
        for (int i = 0; i < 6; i++) begin
            if (nxt_mask[i] && i < NUM_DIG) begin
                pub_dig[4*i +: 4] = nxt_dig[4*i +: 4];
                pub_dp[i]         = nxt_dp[i];
                pub_err[i]        = nxt_err[i];
            end
        end
    end

    // Shadow slots collect the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            shadow_err <= '0;
            slot_mask  <= '0;
        end else begin
            shadow_dig <= nxt_dig;
            shadow_dp  <= nxt_dp;
            shadow_err <= nxt_err;
            slot_mask  <= nxt_mask;
        end
    end

    // Outputs change only on entry to DONE; error pulses follow the FSM decision by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_digits      <= '0;
            o_dp          <= '0;
            o_dec_err     <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_valid <= (next_state == DONE);
            o_frame_err   <= err;
            if (next_state == DONE) begin
                o_digits  <= pub_dig;
                o_dp      <= pub_dp;
                o_dec_err <= pub_err;
            end
        end
    end

`ifdef FND_RX_ERRCNT_EN
    // Protocol error counter: saturating, cleared by every good frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err_cnt <= 8'h00;
        end else if (o_frame_valid) begin
            o_err_cnt <= 8'h00;
        end else if (o_frame_err && o_err_cnt != 8'hFF) begin
            o_err_cnt <= o_err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_fnd_scan_rx.sv
// tb_fnd_scan_rx: scoreboard bench for fnd_scan_rx.
// A frame-level model turns every scanned digit into expected frames or error pulses.
// A separate monitor process compares each DUT pulse against that queue.
module tb_fnd_scan_rx;

    localparam int NUM_DIG     = 6;
    localparam int STABLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 20000;

    typedef struct {
        bit          is_err;
        logic [23:0] dig;
        logic [5:0]  dpv;
        logic [5:0]  derr;
        int          err_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  enb;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic [5:0]  o_dec_err;
    logic        o_frame_valid;
    logic        o_frame_err;
`ifdef FND_RX_ERRCNT_EN
    logic [7:0]  o_err_cnt;
    bit          chk_zero = 1'b0;
`endif

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    logic [6:0]  code_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

    // Reference model state: frame-level view of the protocol.
    bit          m_collect;
    int          m_expect;
    logic [3:0]  m_dig [6];
    bit          m_dp [6];
    bit          m_err [6];
    bit          m_have [6];
    int          m_since;
    logic [13:0] m_last;
    int          m_err_cnt;
    logic [23:0] pub_dig;
    logic [5:0]  pub_dp;
    logic [5:0]  pub_err;

    fnd_scan_rx #(
        .NUM_DIG     (NUM_DIG),
        .STABLE_CYC  (STABLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_seg         (seg),
        .i_seg_dp      (dp),
        .i_seg_enb     (enb),
        .o_digits      (o_digits),
        .o_dp          (o_dp),
        .o_dec_err     (o_dec_err),
        .o_frame_valid (o_frame_valid),
        .o_frame_err   (o_frame_err)
`ifdef FND_RX_ERRCNT_EN
        ,
        .o_err_cnt     (o_err_cnt)
`endif
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] v, output bit e);
        v = 4'hF;
        e = 1'b1;
        if (p == 7'h00) begin
            v = 4'hE;
            e = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (code_tab[i] == p) begin
                v = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    task automatic push_err();
        exp_t e;
        e.is_err  = 1'b1;
        e.dig     = '0;
        e.dpv     = '0;
        e.derr    = '0;
        e.err_cnt = 0;
        exp_q.push_back(e);
        if (m_err_cnt < 255) m_err_cnt++;
    endtask

    task automatic push_valid();
        exp_t e;
        e.is_err  = 1'b0;
        e.dig     = '0;
        e.dpv     = '0;
        e.derr    = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (m_have[i]) begin
                e.dig[4*i +: 4] = m_dig[i];
                e.dpv[i]        = m_dp[i];
                e.derr[i]       = m_err[i];
            end
        end
        e.err_cnt = m_err_cnt;
        m_err_cnt = 0;
        exp_q.push_back(e);
    endtask

    task automatic store_slot(input int k, input logic [6:0] s, input logic d);
        logic [3:0] v;
        bit         e;
        ref_decode(s, v, e);
        m_dig[k]  = v;
        m_dp[k]   = d;
        m_err[k]  = e;
        m_have[k] = 1'b1;
    endtask

    task automatic start_frame(input logic [6:0] s, input logic d);
        for (int i = 0; i < 6; i++) m_have[i] = 1'b0;
        store_slot(0, s, d);
        m_expect = 1;
        m_since  = 0;
        if (NUM_DIG == 1) begin
            push_valid();
            m_collect = 1'b0;
        end else begin
            m_collect = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_collect = 1'b0;
        m_expect  = 0;
        m_since   = 0;
        m_last    = {7'h00, 1'b0, 6'h3F};
        m_err_cnt = 0;
        pub_dig   = '0;
        pub_dp    = '0;
        pub_err   = '0;
        for (int i = 0; i < 6; i++) m_have[i] = 1'b0;
    endtask

    // One scan phase held for dwell clocks: a new, differing vector is one protocol event.
    task automatic model_event(input logic [6:0] s, input logic d, input logic [5:0] en, input int dwell);
        logic [13:0] vec;
        int          zeros;
        int          k;
        vec   = {s, d, en};
        zeros = 0;
        k     = 0;
        for (int i = 0; i < 6; i++) begin
            if (!en[i]) begin
                zeros++;
                k = i;
            end
        end
        if (vec != m_last) begin
            if (!m_collect) begin
                if (zeros == 1 && k == 0) start_frame(s, d);
            end else if (zeros == 1 && k == m_expect) begin
                store_slot(k, s, d);
                m_expect++;
                m_since = 0;
                if (m_expect == NUM_DIG) begin
                    push_valid();
                    m_collect = 1'b0;
                end
            end else if (zeros == 1 && k == 0) begin
                push_err();
                start_frame(s, d);
            end else if ((zeros == 1 && k < NUM_DIG) || zeros > 1) begin
                push_err();
                m_collect = 1'b0;
            end
        end
        m_last = vec;
        if (m_collect) begin
            if (m_since + dwell > TIMEOUT_CYC + 2) begin
                push_err();
                m_collect = 1'b0;
            end else begin
                m_since += dwell;
            end
        end
    endtask

    // Drive one scan phase; optionally flip a segment for one clock at glitch_at.
    task automatic apply_stimulus(input logic [6:0] s, input logic d, input logic [5:0] en,
                                  input int dwell, input int glitch_at = -1);
        model_event(s, d, en, dwell);
        seg = s;
        dp  = d;
        enb = en;
        for (int c = 0; c < dwell; c++) begin
            @(posedge clk);
            #1;
            seg = (c == glitch_at) ? (s ^ 7'h08) : s;
        end
    endtask

    function automatic logic [5:0] onehot_low(input int k);
        logic [5:0] one;
        one = 6'b000001;
        return ~(one << k);
    endfunction

    task automatic send_frame(input logic [23:0] bcd, input logic [5:0] dpv, input int dwell);
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(code_tab[bcd[4*k +: 4]], dpv[k], onehot_low(k), dwell);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seg   = 7'h00;
        dp    = 1'b0;
        enb   = 6'h3F;
        model_reset();
        @(negedge clk);
        check_output("reset_digits", 32'(o_digits), 32'd0);
        check_output("reset_dp", 32'(o_dp), 32'd0);
        check_output("reset_dec_err", 32'(o_dec_err), 32'd0);
        check_output("reset_valid", 32'(o_frame_valid), 32'd0);
        check_output("reset_err", 32'(o_frame_err), 32'd0);
`ifdef FND_RX_ERRCNT_EN
        check_output("reset_err_cnt", 32'(o_err_cnt), 32'd0);
`endif
        check_output("reset_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT pulse must match the head of the expectation queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
`ifdef FND_RX_ERRCNT_EN
            if (chk_zero) begin
                chk_zero = 1'b0;
                check_output("err_cnt_cleared", 32'(o_err_cnt), 32'd0);
            end
`endif
            if (rst_n && (o_frame_valid || o_frame_err)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b, required no pulse",
                             o_frame_valid, o_frame_err);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pulse_kind", 32'({o_frame_err, o_frame_valid}),
                                 e.is_err ? 32'd2 : 32'd1);
                    if (!e.is_err) begin
                        check_output("frame_digits", 32'(o_digits), 32'(e.dig));
                        check_output("frame_dp", 32'(o_dp), 32'(e.dpv));
                        check_output("frame_dec_err", 32'(o_dec_err), 32'(e.derr));
`ifdef FND_RX_ERRCNT_EN
                        check_output("err_cnt_at_valid", 32'(o_err_cnt), 32'(e.err_cnt));
                        chk_zero = 1'b1;
`endif
                        pub_dig = e.dig;
                        pub_dp  = e.dpv;
                        pub_err = e.derr;
                    end else begin
                        check_output("digits_held_on_err", 32'(o_digits), 32'(pub_dig));
                        check_output("dec_err_held_on_err", 32'(o_dec_err), 32'(pub_err));
                    end
                end
            end
        end
    end

    // Watchdog so a stuck DUT can never hang the run.
    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no end of test, required finish within 80000 clocks");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int         mode;
        int         r;
        int         a;
        int         b;
        logic [6:0] pat;
        logic [5:0] men;
        int         sel;
        seg = 7'h00;
        dp  = 1'b0;
        enb = 6'h3F;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Plain frame 1..6 with a long dwell.
        send_frame(24'h654321, 6'b000000, 500);

        // One-clock glitch while digit 2 is settling.
        apply_stimulus(code_tab[1], 1'b0, onehot_low(0), 30);
        apply_stimulus(code_tab[2], 1'b0, onehot_low(1), 30);
        apply_stimulus(code_tab[3], 1'b0, onehot_low(2), 30, 0);
        apply_stimulus(code_tab[4], 1'b0, onehot_low(3), 30);
        apply_stimulus(code_tab[5], 1'b0, onehot_low(4), 30);
        apply_stimulus(code_tab[6], 1'b0, onehot_low(5), 30);

        // Skipped digit, then a good frame with decimal points.
        apply_stimulus(code_tab[0], 1'b0, onehot_low(0), 20);
        apply_stimulus(code_tab[1], 1'b0, onehot_low(1), 20);
        apply_stimulus(code_tab[3], 1'b0, onehot_low(3), 20);
        send_frame(24'h098765, 6'b100101, 20);

        // Illegal pattern on digit 4.
        for (int k = 0; k < 6; k++) begin
            apply_stimulus((k == 4) ? 7'h01 : code_tab[k], 1'b0, onehot_low(k), 20);
        end

        // Two enables at once, then a stall past the timeout, then recovery.
        apply_stimulus(code_tab[2], 1'b0, onehot_low(0), 20);
        apply_stimulus(code_tab[3], 1'b0, onehot_low(1), 20);
        apply_stimulus(code_tab[4], 1'b0, 6'b111100, 20);
        apply_stimulus(code_tab[2], 1'b0, onehot_low(0), 20);
        apply_stimulus(code_tab[3], 1'b0, onehot_low(1), 20);
        apply_stimulus(code_tab[4], 1'b0, onehot_low(2), TIMEOUT_CYC + 50);
        send_frame(24'h112233, 6'b010000, 20);

        // Reset in the middle of a frame, then a full frame.
        for (int k = 0; k < 4; k++) apply_stimulus(code_tab[k + 5], 1'b1, onehot_low(k), 20);
        do_reset();
        send_frame(24'h908172, 6'b001100, 20);

        // Three aborted frames followed by a good one.
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(code_tab[n], 1'b0, onehot_low(0), 20);
            apply_stimulus(code_tab[n], 1'b0, onehot_low(2), 20);
        end
        send_frame(24'h445566, 6'b000011, 20);

        // Randomised frames with occasional protocol faults and odd patterns.
        for (int f = 0; f < 25; f++) begin
            mode = $urandom_range(0, 5);
            r    = $urandom_range(1, 5);
            for (int k = 0; k < 6; k++) begin
                sel = $urandom_range(0, 9);
                if (sel < 8)       pat = code_tab[$urandom_range(0, 9)];
                else if (sel == 8) pat = 7'h00;
                else               pat = 7'($urandom);
                if (k == r && mode == 1) continue;
                if (k == r && mode == 2) begin
                    a   = $urandom_range(0, 5);
                    b   = (a + 1 + $urandom_range(0, 4)) % 6;
                    men = 6'($urandom) & onehot_low(a) & onehot_low(b);
                    apply_stimulus(pat, 1'b0, men, $urandom_range(12, 40));
                end
                if (k == r && mode == 3) begin
                    apply_stimulus(7'h00, 1'b0, 6'h3F, $urandom_range(12, 40));
                end
                if (k == r && mode == 4) begin
                    apply_stimulus(code_tab[$urandom_range(0, 9)], 1'($urandom), onehot_low(0),
                                   $urandom_range(12, 40));
                end
                apply_stimulus(pat, 1'($urandom), onehot_low(k), $urandom_range(12, 40));
            end
        end

        // Let the last expectations drain, bounded.
        apply_stimulus(7'h00, 1'b0, 6'h3F, 20);
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
